// File: rtl/rv_fwd_pkg.sv
// Shared definitions for the operand-forwarding and load-use hazard logic:
// the mux select codes, the shadow-pipeline entry and its match helper.
package rv_fwd_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;
  localparam logic [1:0] FWD_RET     = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } shadow_t;

  // x0 is hardwired to zero, so it never has a producer.
  function automatic logic produces(shadow_t e, logic [REG_ADDR_W-1:0] r);
    return e.valid & e.reg_write & (e.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_select_gen.sv
// Resolves one source register against the shadow pipeline: the nearest
// producer wins. Also flags a load in EX that this operand depends on.
module fwd_select_gen
  import rv_fwd_pkg::*;
(
  input  logic                  use_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  shadow_t               sh_ex_i,
  input  shadow_t               sh_mem_i,
  input  shadow_t               sh_wb_i,
  output logic [1:0]            sel_o,
  output logic                  load_hit_o
);

  logic hit_ex, hit_mem, hit_wb;

  assign hit_ex  = use_i & produces(sh_ex_i, rs_i);
  assign hit_mem = use_i & produces(sh_mem_i, rs_i);
  assign hit_wb  = use_i & produces(sh_wb_i, rs_i);

  assign load_hit_o = hit_ex & sh_ex_i.mem_read;

  always_comb begin
    sel_o = FWD_REGFILE;
    if (hit_ex) begin
      sel_o = FWD_EXMEM;
    end else if (hit_mem) begin
      sel_o = FWD_MEMWB;
    end else if (hit_wb) begin
      sel_o = FWD_RET;
    end
  end

  // Older loads have already produced their data; only the EX entry can stall.
  logic unused_mem_read;
  assign unused_mem_read = sh_mem_i.mem_read ^ sh_wb_i.mem_read;

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks destination metadata for EX/MEM/WB, registers ALU operand-mux selects
// into EX and raises a load-use stall with a saturating stall counter.
module forward_hazard_unit #(
  // Must equal the package width, which fixes the shadow entry layout.
  parameter int unsigned REG_ADDR_W  = rv_fwd_pkg::REG_ADDR_W,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   hold,
  input  logic                   flush,
  output logic [1:0]             fwd_sel_a,
  output logic [1:0]             fwd_sel_b,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  import rv_fwd_pkg::shadow_t;
  import rv_fwd_pkg::FWD_REGFILE;

  shadow_t sh_ex_q, sh_ex_d, sh_mem_q, sh_wb_q;

  logic [1:0]             sel_a, sel_b;
  logic                   load_hit_a, load_hit_b;
  logic [1:0]             fwd_sel_a_q, fwd_sel_a_d, fwd_sel_b_q, fwd_sel_b_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  fwd_select_gen u_sel_a (
    .use_i      (id_use_rs1),
    .rs_i       (id_rs1),
    .sh_ex_i    (sh_ex_q),
    .sh_mem_i   (sh_mem_q),
    .sh_wb_i    (sh_wb_q),
    .sel_o      (sel_a),
    .load_hit_o (load_hit_a)
  );

  fwd_select_gen u_sel_b (
    .use_i      (id_use_rs2),
    .rs_i       (id_rs2),
    .sh_ex_i    (sh_ex_q),
    .sh_mem_i   (sh_mem_q),
    .sh_wb_i    (sh_wb_q),
    .sel_o      (sel_b),
    .load_hit_o (load_hit_b)
  );

  assign stall = id_valid & ~flush & (load_hit_a | load_hit_b);

  always_comb begin
    sh_ex_d       = '0;
    fwd_sel_a_d   = FWD_REGFILE;
    fwd_sel_b_d   = FWD_REGFILE;
    stall_count_d = stall_count_q;
    if (id_valid && !stall && !flush) begin
      sh_ex_d = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
      fwd_sel_a_d = sel_a;
      fwd_sel_b_d = sel_b;
    end
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // hold freezes every register; flush cannot coincide with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_ex_q       <= '0;
      sh_mem_q      <= '0;
      sh_wb_q       <= '0;
      fwd_sel_a_q   <= FWD_REGFILE;
      fwd_sel_b_q   <= FWD_REGFILE;
      stall_count_q <= '0;
    end else if (!hold) begin
      sh_wb_q       <= sh_mem_q;
      sh_mem_q      <= sh_ex_q;
      sh_ex_q       <= sh_ex_d;
      fwd_sel_a_q   <= fwd_sel_a_d;
      fwd_sel_b_q   <= fwd_sel_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_sel_a   = fwd_sel_a_q;
  assign fwd_sel_b   = fwd_sel_b_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_forward_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, hold, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] sel_a, sel_b, sel_a_s, sel_b_s;
  logic       stall, stall_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  forward_hazard_unit u_dut (
    .CLK          (clk),
    .RESET        (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .hold         (hold),
    .flush        (flush),
    .fwd_sel_a    (sel_a),
    .fwd_sel_b    (sel_b),
    .stall        (stall),
    .stall_count  (cnt)
  );

  forward_hazard_unit #(.STALL_CNT_W(2)) u_dut_small (
    .CLK          (clk),
    .RESET        (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .hold         (hold),
    .flush        (flush),
    .fwd_sel_a    (sel_a_s),
    .fwd_sel_b    (sel_b_s),
    .stall        (stall_s),
    .stall_count  (cnt_s)
  );

  always @(posedge clk) assert (!(hold && flush));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ex(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    check_eq({tag, ".sel_a"}, 32'(sel_a), 32'(ea));
    check_eq({tag, ".sel_b"}, 32'(sel_b), 32'(eb));
  endtask

  task automatic check_cnt(input string tag);
    check_eq({tag, ".cnt"}, 32'(cnt), exp_cnt);
    check_eq({tag, ".cnt_small"}, 32'(cnt_s), (exp_cnt > 3) ? 3 : exp_cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic rw, input logic mr);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
    drive(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    check_eq("rst.stall", 32'(stall), 0);
    check_ex("rst", 2'b00, 2'b00);
    check_cnt("rst");
    rst = 1'b0;

    // Back-to-back ALU dependency
    alu(5, 1, 2);  check_eq("b2b.stall0", 32'(stall), 0); cyc();
    check_ex("b2b.prod", 2'b00, 2'b00);
    alu(6, 5, 7);  check_eq("b2b.stall1", 32'(stall), 0); cyc();
    check_ex("b2b.cons", 2'b01, 2'b00);

    // Distance 2, 3 and out of range
    alu(12, 1, 2); cyc(); alu(13, 1, 2); cyc(); alu(14, 1, 12); cyc();
    check_ex("dist2", 2'b00, 2'b10);
    alu(15, 1, 2); cyc(); alu(16, 1, 2); cyc(); alu(17, 1, 2); cyc();
    alu(18, 1, 15); cyc();
    check_ex("dist3", 2'b00, 2'b11);
    alu(19, 1, 15); cyc();
    check_ex("dist4", 2'b00, 2'b00);

    // Load-use: one stall cycle, bubble, then MEM/WB forwarding
    load(8, 1); cyc();
    alu(9, 8, 8); check_eq("lu.stall", 32'(stall), 1); cyc(); exp_cnt++;
    check_ex("lu.bubble", 2'b00, 2'b00);
    check_cnt("lu.bubble");
    check_eq("lu.stall_gone", 32'(stall), 0); cyc();
    check_ex("lu.fwd", 2'b10, 2'b10);
    check_cnt("lu.fwd");

    // x0 never forwards, even from a load
    alu(0, 1, 2); cyc(); alu(0, 1, 2); cyc(); alu(20, 0, 0); cyc();
    check_ex("x0.alu", 2'b00, 2'b00);
    load(0, 1); cyc();
    alu(21, 0, 0); check_eq("x0.load_stall", 32'(stall), 0); cyc();
    check_ex("x0.load", 2'b00, 2'b00);

    // Nearest producer wins, same register on both operands
    alu(3, 1, 2); cyc(); alu(3, 1, 2); cyc(); alu(22, 3, 3); cyc();
    check_ex("nearest", 2'b01, 2'b01);

    // Unused operands do not forward or stall
    alu(23, 1, 2); cyc();
    drive(1'b1, 24, 23, 23, 1'b0, 1'b1, 1'b1, 1'b0); cyc();
    check_ex("unused", 2'b00, 2'b01);
    load(25, 1); cyc();
    drive(1'b1, 26, 25, 25, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("unused.stall", 32'(stall), 0); cyc();

    // Flush during a load-use cycle
    load(8, 1); cyc();
    flush = 1'b1; alu(9, 8, 8);
    check_eq("flush.stall", 32'(stall), 0); cyc();
    flush = 1'b0;
    check_ex("flush.bubble", 2'b00, 2'b00);
    check_cnt("flush");
    alu(27, 8, 1); check_eq("flush.mem_stall", 32'(stall), 0); cyc();
    check_ex("flush.mem", 2'b10, 2'b00);

    // Hold freezes everything, then the stream resumes
    alu(24, 1, 2); cyc(); alu(25, 24, 1); cyc();
    check_ex("hold.pre", 2'b01, 2'b00);
    hold = 1'b1; alu(26, 25, 24);
    repeat (4) begin
      cyc();
      check_ex("hold.frozen", 2'b01, 2'b00);
    end
    check_cnt("hold.frozen");
    hold = 1'b0; cyc();
    check_ex("hold.post", 2'b01, 2'b10);

    // Hold during a stall: counter waits for the hold to drop
    load(28, 1); cyc();
    hold = 1'b1; alu(29, 28, 1);
    check_eq("holdstall.stall", 32'(stall), 1);
    cyc(); cyc();
    check_cnt("holdstall.frozen");
    hold = 1'b0; cyc(); exp_cnt++;
    check_cnt("holdstall.release");
    check_ex("holdstall.bubble", 2'b00, 2'b00);
    cyc();
    check_ex("holdstall.fwd", 2'b10, 2'b00);

    // Three more stalls: 5 total, small counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      load(30, 1); cyc();
      alu(31, 30, 1); cyc(); exp_cnt++;
      cyc();
      check_ex("sat.fwd", 2'b10, 2'b00);
    end
    check_cnt("sat");

    // Reset while a stall is pending
    load(8, 1); cyc();
    alu(9, 8, 8); check_eq("rststall.pre", 32'(stall), 1);
    rst = 1'b1; cyc(); exp_cnt = 0;
    check_eq("rststall.stall", 32'(stall), 0);
    check_ex("rststall", 2'b00, 2'b00);
    check_cnt("rststall");
    rst = 1'b0; cyc();
    check_ex("rststall.post", 2'b00, 2'b00);
    check_eq("rststall.post_stall", 32'(stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
